// File: rtl/mult_job_sequencer.sv
// mult_job_sequencer: job FIFO, one-at-a-time launch and held result slot for a
// shift-add multiplier core, with a DONE watchdog.  Rev 1.0
`default_nettype none

module mult_job_sequencer #(
    parameter int N       = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 160
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [N-1:0]   in_plier_i,
    input  logic [N-1:0]   in_cand_i,
    output logic           mul_st_o,
    output logic [N-1:0]   mul_plier_o,
    output logic [N-1:0]   mul_cand_o,
    input  logic           mul_done_i,
    input  logic [2*N-1:0] mul_product_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [2*N-1:0] out_product_o,
    output logic           out_err_o,
    output logic           busy_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t           state_q;
    logic [N-1:0]     plier_mem [DEPTH];
    logic [N-1:0]     cand_mem  [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             in_ready_q;
    logic             mul_st_q;
    logic [N-1:0]     mul_plier_q, mul_cand_q;
    logic             out_valid_q;
    logic [2*N-1:0]   out_product_q;
    logic             out_err_q;
    logic [WW-1:0]    wdog_q;
    logic             do_push, do_pop;

    assign do_push = in_valid_i && in_ready_q;
    // Launch waits for an empty result slot so capture and accept never collide.
    assign do_pop  = (state_q == S_IDLE) && (count_q != '0) && !out_valid_q;

    always_comb begin
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            plier_mem[wr_ptr_q] <= in_plier_i;
            cand_mem[wr_ptr_q]  <= in_cand_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            in_ready_q    <= 1'b0;
            mul_st_q      <= 1'b0;
            mul_plier_q   <= '0;
            mul_cand_q    <= '0;
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
            out_err_q     <= 1'b0;
            wdog_q        <= '0;
        end else begin
            count_q    <= count_d;
            in_ready_q <= (count_d != CW'(DEPTH));
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (out_valid_q && out_ready_i) out_valid_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    mul_st_q <= 1'b0;
                    if (do_pop) begin
                        mul_plier_q <= plier_mem[rd_ptr_q];
                        mul_cand_q  <= cand_mem[rd_ptr_q];
                        mul_st_q    <= 1'b1;
                        state_q     <= S_START;
                    end
                end
                S_START: begin
                    mul_st_q <= 1'b0;
                    wdog_q   <= '0;
                    state_q  <= S_WAIT;
                end
                S_WAIT: begin
                    mul_st_q <= 1'b0;
                    // wdog_q==0 marks the first WAIT cycle, where a stale DONE is ignored.
                    if (mul_done_i && (wdog_q != '0)) begin
                        out_product_q <= mul_product_i;
                        out_err_q     <= 1'b0;
                        out_valid_q   <= 1'b1;
                        state_q       <= S_IDLE;
                    end else if (wdog_q == WW'(TIMEOUT - 1)) begin
                        out_product_q <= '0;
                        out_err_q     <= 1'b1;
                        out_valid_q   <= 1'b1;
                        state_q       <= S_IDLE;
                    end else begin
                        wdog_q <= wdog_q + WW'(1);
                    end
                end
                default: begin
                    mul_st_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o    = in_ready_q;
    assign mul_st_o      = mul_st_q;
    assign mul_plier_o   = mul_plier_q;
    assign mul_cand_o    = mul_cand_q;
    assign out_valid_o   = out_valid_q;
    assign out_product_o = out_product_q;
    assign out_err_o     = out_err_q;
    assign busy_o        = (state_q != S_IDLE) || (count_q != '0);

endmodule

`default_nettype wire
